l1_cache_2way: RTL and testbench
================================

// Module: l1_cache_2way
// PURPOSE
// - Two-way set-associative L1 data cache with LRU replacement, instantiated inside the MMU in front of word RAM.
// - Lookup is combinational: hit flag and read word are valid in the same cycle as mem_addr.
// - Line refill is driven by the MMU through a word-wise fill port; CPU writes are write-through by the MMU.
// - Write hits update the cache; write misses do not allocate.
// PARAMETERS
// - DATA_WIDTH  32    word width in bits
// - ADDR_WIDTH  32    byte address width
// - CACHE_SIZE  4096  total data capacity in bytes
// - LINE_SIZE   16    line size in bytes (4 words)
// - WAYS        2     associativity; only 2 is supported
// PORTS
// - clk              in   1           rising-edge clock
// - rst              in   1           synchronous active-high reset
// - mem_valid        in   1           CPU access present this cycle
// - mem_we           in   1           1 = store, 0 = load
// - mem_addr         in   ADDR_WIDTH  byte address; word aligned, bits [1:0] ignored
// - mem_w_data       in   DATA_WIDTH  store data
// - mem_r_data       out  DATA_WIDTH  hit word; combinational
// - cache_hit        out  1           combinational hit indication
// - fill_en          in   1           write fill_data into the victim line
// - fill_addr        in   ADDR_WIDTH  address of the fill word
// - fill_data        in   DATA_WIDTH  refill word
// - fill_mark_valid  in   1           last fill word: commit tag and valid bit
// BEHAVIOUR
// - Geometry: SETS = CACHE_SIZE/(LINE_SIZE*WAYS) = 128.
// - Address split: offset = addr[3:0], word select = addr[3:2], index = addr[10:4], tag = addr[31:11] (defaults).
// - Per set: 2 x {valid, tag, 4 words}, plus 1 LRU bit (0 = way0 is the victim).
// - cache_hit = mem_valid & (way0 valid & tag match | way1 valid & tag match).
// - mem_r_data = word of the hit way, or 0 when there is no hit.
// - If both ways match (illegal case), way0 wins.
// - Read hit: at the clk edge, LRU of the set points to the non-hit way.
// - Write hit (mem_valid & mem_we & hit): at the clk edge, the word in the hit way is overwritten and LRU updated.
// - Write miss: no state change.
// - Fill: on fill_en, fill_data is written to word fill_addr[3:2] of the victim way (LRU) of set fill_addr[10:4].
// - The victim way does not change while filling.
// - On fill_en & fill_mark_valid (same cycle as the 4th word): the victim way's tag is set from fill_addr, valid is set, and LRU flips to the other way.
// - During a fill, the victim's valid bit is cleared on the first fill_en, so stale data is never hit.
// - Simultaneous fill_en and CPU write: the fill has priority and the CPU write is dropped.
// - A read-hit LRU update is suppressed while fill_en = 1.
// - Reset: all valid bits and LRU bits cleared on the clk edge with rst = 1.
// - Data arrays are not reset. Outputs are combinational, so after reset cache_hit = 0 and mem_r_data = 0.
// - Reset during a fill abandons it; the line stays invalid.
// CONFIGURATION
// - Macro CACHE_STATS_EN: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//   - Counters increment on each cycle with mem_valid & !mem_we & !fill_en, by hit or miss.
//   - Counters clear on rst and wrap at 2^32.
// - Without CACHE_STATS_EN: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING
// - After rst, read 0x100 -> cache_hit = 0, mem_r_data = 0.
// - Fill 0x100..0x10C with 11,22,33,44, mark_valid on 0x10C -> read 0x108: hit = 1, data = 33.
// - Fill set 16 with tag A (0x100) then tag B (0x900), read 0x100, then fill tag C (0x1100).
//   -> 0x900 misses, 0x100 and 0x1100 hit (LRU evicted B).
// - Write hit 0x104 with 0xDEADBEEF -> next-cycle read 0x104 = 0xDEADBEEF.
// - Write miss to 0x2000 -> subsequent read 0x2000 misses.
// - Assert rst mid-fill after 2 words -> read of that line misses; previously valid lines also miss.

Source files
------------

// File: rtl/l1_cache_2way.sv
// l1_cache_2way
//   Two-way set-associative L1 data cache with LRU replacement, placed inside
//   the MMU in front of word RAM. Lookup is combinational. Refill is pushed in
//   word by word by the MMU. Stores are written through by the MMU, so the
//   cache only updates itself on a write hit. It never allocates on a write.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   mem_valid/mem_we         CPU access present / store
//   mem_addr, mem_w_data     byte address (bits [1:0] ignored), store data
//   mem_r_data, cache_hit    combinational hit word (0 on miss) and hit flag
//   fill_en/fill_addr/data   refill word into the victim way of fill_addr's set
//   fill_mark_valid          last refill word: commit tag, set valid, flip LRU
//
// Optional feature: define CACHE_STATS_EN to add hit_cnt / miss_cnt load
// counters. With the macro undefined, those ports do not exist.
module l1_cache_2way #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 16,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  cache_hit,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  fill_mark_valid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(BYTES);
  localparam int WORDS  = LINE_SIZE / BYTES;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int SETS   = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;

  // Per-set state. Only valid and LRU are reset.
  logic [SETS-1:0]       r_valid [WAYS];
  logic [SETS-1:0]       r_lru;      // 0: way0 is the victim, 1: way1
  logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
  logic [DATA_WIDTH-1:0] r_data  [WAYS][SETS][WORDS];

  // CPU-side address split.
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WSEL_W-1:0] w_wsel;
  assign w_idx  = mem_addr[OFF_W +: IDX_W];
  assign w_tag  = mem_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_wsel = mem_addr[BYTE_W +: WSEL_W];

  // Fill-side address split.
  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic [WSEL_W-1:0] w_f_wsel;
  logic              w_victim;
  assign w_f_idx  = fill_addr[OFF_W +: IDX_W];
  assign w_f_tag  = fill_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_f_wsel = fill_addr[BYTE_W +: WSEL_W];
  // The victim is stable for the whole fill. After the first word the victim
  // is invalid, so no access can hit it and move LRU. Read-hit LRU updates are
  // also blocked on cycles that carry a fill word.
  assign w_victim = r_lru[w_f_idx];

  // Byte-offset bits are ignored by design.
  logic w_unused;
  assign w_unused = ^{mem_addr[BYTE_W-1:0], fill_addr[BYTE_W-1:0]};

  logic [WAYS-1:0] w_way_hit;
  logic            w_hit;
  logic            w_hit_way;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_way_hit[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
  end

  // Way0 takes precedence if both ways ever carry the same tag.
  assign w_hit_way  = ~w_way_hit[0];
  assign w_hit      = mem_valid & (|w_way_hit);
  assign cache_hit  = w_hit;
  assign mem_r_data = w_hit ? r_data[w_hit_way][w_idx][w_wsel] : '0;

  // Valid / LRU state. A fill word takes priority over any CPU access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_lru <= '0;
    end else if (fill_en) begin
      if (fill_mark_valid) begin
        r_valid[w_victim][w_f_idx] <= 1'b1;
        r_lru[w_f_idx]             <= ~w_victim;
      end else begin
        // Invalidate on the first word so a half-refilled line never hits.
        r_valid[w_victim][w_f_idx] <= 1'b0;
      end
    end else if (w_hit) begin
      r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tag and data arrays. These are not reset. A CPU store is dropped when it
  // collides with a fill word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        r_data[w_victim][w_f_idx][w_f_wsel] <= fill_data;
        if (fill_mark_valid) r_tag[w_victim][w_f_idx] <= w_f_tag;
      end else if (w_hit && mem_we) begin
        r_data[w_hit_way][w_idx][w_wsel] <= mem_w_data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Load-only statistics. Cycles that carry a fill word are not counted.
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (mem_valid && !mem_we && !fill_en) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l1_cache_2way.sv
// Bench for l1_cache_2way. It starts with directed scenarios, then runs
// randomized loads, stores and refills. A line-level reference model judges
// every cycle. The model tracks recency with use timestamps, not an LRU bit.
module tb_l1_cache_2way;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        cache_hit;
  logic        fill_en, fill_mark_valid;
  logic [31:0] fill_addr, fill_data;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l1_cache_2way dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .cache_hit(cache_hit),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_mark_valid(fill_mark_valid)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. Each set holds two line slots. The victim is the slot
  // used least recently. On a tie (both never used since reset) it is slot 0.
  bit          m_val [2][128];
  int unsigned m_tag [2][128];
  logic [31:0] m_dat [2][128][4];
  int unsigned m_ts  [2][128];
  int unsigned m_now = 0;
  int unsigned m_hits = 0, m_miss = 0;

  function automatic int m_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_val[w][a[10:4]] && m_tag[w][a[10:4]] == (a >> 11)) return w;
    return -1;
  endfunction

  function automatic int m_victim(input logic [6:0] s);
    return (m_ts[1][s] < m_ts[0][s]) ? 1 : 0;
  endfunction

  // One clock cycle: compare the outputs against the model, then advance the model.
  task automatic step();
    int          w, v;
    bit          eh;
    logic [31:0] ed;
    @(negedge clk);
    w  = m_way(mem_addr);
    eh = mem_valid && (w >= 0);
    ed = eh ? m_dat[w][mem_addr[10:4]][mem_addr[3:2]] : 32'd0;
    if (!rst) begin
      chk("hit", {31'd0, cache_hit}, {31'd0, eh});
      chk("rdata", mem_r_data, ed);
`ifdef CACHE_STATS_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_miss);
`endif
    end
    @(posedge clk);
    if (rst) begin
      for (int a = 0; a < 2; a++)
        for (int s = 0; s < 128; s++) begin
          m_val[a][s] = 1'b0;
          m_ts[a][s]  = 0;
        end
      m_hits = 0;
      m_miss = 0;
    end else begin
      if (mem_valid && !mem_we && !fill_en) begin
        if (eh) m_hits++;
        else    m_miss++;
      end
      if (fill_en) begin
        v = m_victim(fill_addr[10:4]);
        m_dat[v][fill_addr[10:4]][fill_addr[3:2]] = fill_data;
        if (fill_mark_valid) begin
          m_tag[v][fill_addr[10:4]] = fill_addr >> 11;
          m_val[v][fill_addr[10:4]] = 1'b1;
          m_ts[v][fill_addr[10:4]]  = ++m_now;
        end else begin
          m_val[v][fill_addr[10:4]] = 1'b0;
        end
      end else if (eh) begin
        m_ts[w][mem_addr[10:4]] = ++m_now;
        if (mem_we) m_dat[w][mem_addr[10:4]][mem_addr[3:2]] = mem_w_data;
      end
    end
    #1;
  endtask

  task automatic cpu_idle();
    mem_valid = 0; mem_we = 0; mem_addr = 0; mem_w_data = 0;
  endtask

  task automatic fill_idle();
    fill_en = 0; fill_mark_valid = 0; fill_addr = 0; fill_data = 0;
  endtask

  // Directed access: the constant expectation is checked in the same cycle,
  // before the model-based check inside step().
  task automatic acc(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input bit eh, input logic [31:0] ed, input string tag);
    fill_idle();
    mem_valid = 1; mem_we = we; mem_addr = a; mem_w_data = wd;
    #2;
    chk({tag, "_hit"}, {31'd0, cache_hit}, {31'd0, eh});
    if (!we) chk({tag, "_data"}, mem_r_data, ed);
    step();
  endtask

  task automatic fill_word(input logic [31:0] a, input logic [31:0] d, input bit last);
    fill_en = 1; fill_addr = a; fill_data = d; fill_mark_valid = last;
    step();
  endtask

  task automatic fill_line(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
    cpu_idle();
    fill_word(base,       d0, 0);
    fill_word(base + 4,   d1, 0);
    fill_word(base + 8,   d2, 0);
    fill_word(base + 12,  d3, 1);
    fill_idle();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t, s, w;
    t = $urandom_range(2, 0);
    s = 16 + $urandom_range(1, 0);
    w = $urandom_range(3, 0);
    return (t << 11) | (s << 4) | (w << 2) | $urandom_range(3, 0);
  endfunction

  task automatic cpu_rand();
    mem_valid  = ($urandom_range(3, 0) != 0);
    mem_we     = ($urandom_range(2, 0) == 0);
    mem_addr   = rand_addr();
    mem_w_data = $urandom;
  endtask

  initial begin
    logic [31:0] base;
    cpu_idle();
    fill_idle();
    rst = 1;
    step();
    step();
    rst = 0;

    acc(0, 32'h100, 0, 0, 0, "reset_read");
    fill_line(32'h100, 11, 22, 33, 44);
    acc(0, 32'h108, 0, 1, 33, "fill_read");
    fill_line(32'h900, 55, 66, 77, 88);
    acc(0, 32'h100, 0, 1, 11, "touch_a");
    fill_line(32'h1100, 1, 2, 3, 4);
    acc(0, 32'h900,  0, 0, 0, "evicted_b");
    acc(0, 32'h100,  0, 1, 11, "kept_a");
    acc(0, 32'h110C, 0, 1, 4, "new_c");
    acc(1, 32'h104, 32'hDEADBEEF, 1, 0, "wr_hit");
    acc(0, 32'h104, 0, 1, 32'hDEADBEEF, "wr_read");
    acc(1, 32'h2000, 32'h12345678, 0, 0, "wr_miss");
    acc(0, 32'h2000, 0, 0, 0, "wr_miss_read");

    cpu_idle();
    fill_word(32'h3000, 9, 0);
    fill_word(32'h3004, 8, 0);
    fill_idle();
    rst = 1;
    step();
    rst = 0;
    acc(0, 32'h3000, 0, 0, 0, "mid_fill_rst");
    acc(0, 32'h100,  0, 0, 0, "rst_old_line");

    for (int it = 0; it < 500; it++) begin
      int op;
      op = $urandom_range(59, 0);
      if (op == 0) begin
        cpu_idle(); fill_idle();
        rst = 1; step(); rst = 0;
      end else if (op < 20) begin
        base = rand_addr() & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(2, 0) == 0) begin
            fill_idle(); cpu_rand(); step();
          end
          cpu_rand();
          fill_en = 1; fill_mark_valid = (k == 3);
          fill_addr = base | (k << 2) | $urandom_range(3, 0);
          fill_data = $urandom;
          step();
        end
        fill_idle();
      end else begin
        fill_idle(); cpu_rand(); step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
